vga_fb_arbiter: RTL

- Shares one single-port synchronous framebuffer RAM between two users: the VGA scan-out path (driven by vga_sync timing) and a pixel writer (draw engine or CPU).
- Scan-out always wins its slot. Writes are buffered in an internal FIFO and drained in free RAM cycles.
- Emits pixel data with h_sync, v_sync and video_on delayed to match, so the colour DAC sees aligned signals.

---
 rtl/vga_fb_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port framebuffer between VGA scan-out and a FIFO-buffered writer; FB_DOUBLE_BUF_EN adds bank swap at vblank.
// Latency: rgb_out and delayed syncs lag their scan slot by 2 clk; queued writes reach RAM no earlier than 1 clk after push.
// Backpressure: scan slots are never stalled; wr_ready drops only while the write FIFO is full (or in reset).
module vga_fb_arbiter #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int SCALE_SH   = 2,
  parameter int ADDR_W     = 15,
  parameter int PIX_W      = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
`ifdef FB_DOUBLE_BUF_EN
  input  logic                              i_swap_req,
  output logic                              o_front_bank,
`endif
  input  logic                              i_pix_ce,
  input  logic [9:0]                        i_pixel_x,
  input  logic [9:0]                        i_pixel_y,
  input  logic                              i_video_on,
  input  logic                              i_h_sync_in,
  input  logic                              i_v_sync_in,
  input  logic                              i_wr_valid,
  output logic                              o_wr_ready,
  input  logic [ADDR_W-1:0]                 i_wr_addr,
  input  logic [PIX_W-1:0]                  i_wr_data,
  output logic                              o_wr_err,
  output logic [$clog2(FIFO_DEPTH):0]       o_fifo_level,
`ifdef FB_DOUBLE_BUF_EN
  output logic [ADDR_W:0]                   o_mem_addr,
`else
  output logic [ADDR_W-1:0]                 o_mem_addr,
`endif
  output logic                              o_mem_we,
  output logic [PIX_W-1:0]                  o_mem_wdata,
  input  logic [PIX_W-1:0]                  i_mem_rdata,
  output logic [PIX_W-1:0]                  o_rgb_out,
  output logic                              o_h_sync_out,
  output logic                              o_v_sync_out,
  output logic                              o_video_on_out
);
`ifdef FB_DOUBLE_BUF_EN
  localparam int MEM_AW = ADDR_W + 1;
`else
  localparam int MEM_AW = ADDR_W;
`endif
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = LVL_W - 1;
  localparam logic [31:0] FB_W = 32'(H_ACTIVE >> SCALE_SH);
  localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'((H_ACTIVE >> SCALE_SH) * (V_ACTIVE >> SCALE_SH));

  typedef struct packed {
`ifdef FB_DOUBLE_BUF_EN
    logic              bank;
`endif
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
  } wr_ent_t;

  typedef enum logic {ST_BLANK, ST_ACTIVE} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_run;
  wr_ent_t           r_fifo [FIFO_DEPTH];
  logic [LVL_W-1:0]  r_wptr, r_rptr;
  logic [LVL_W-1:0]  w_level;
  logic              w_full, w_empty, w_push, w_pop, w_scan, w_we, w_err;
  wr_ent_t           w_head, w_push_ent;
  logic [ADDR_W-1:0] w_scan_addr;
  logic [MEM_AW-1:0] w_scan_maddr, w_head_maddr, w_maddr;
  logic              r_scan_d1;
  logic [PIX_W-1:0]  r_rgb;
  logic [1:0]        r_hs, r_vs, r_vid;

  assign w_scan_addr = ADDR_W'((32'(i_pixel_y) >> SCALE_SH) * FB_W + (32'(i_pixel_x) >> SCALE_SH));

`ifdef FB_DOUBLE_BUF_EN
  logic r_front, r_swap_pend, r_vs_prev;
  logic w_vs_fall;
  assign w_vs_fall = r_vs_prev & ~i_v_sync_in;

  // A request arriving on the swap cycle itself stays pending for the next vblank.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_front     <= 1'b0;
      r_swap_pend <= 1'b0;
      r_vs_prev   <= 1'b1;
    end else begin
      r_vs_prev <= i_v_sync_in;
      if (w_vs_fall && r_swap_pend) begin
        r_front     <= ~r_front;
        r_swap_pend <= i_swap_req;
      end else if (i_swap_req) begin
        r_swap_pend <= 1'b1;
      end
    end
  end

  assign o_front_bank = r_front;
  assign w_push_ent   = '{bank: ~r_front, addr: i_wr_addr, data: i_wr_data};
  assign w_scan_maddr = {r_front, w_scan_addr};
  assign w_head_maddr = {w_head.bank, w_head.addr};
`else
  assign w_push_ent   = '{addr: i_wr_addr, data: i_wr_data};
  assign w_scan_maddr = w_scan_addr;
  assign w_head_maddr = w_head.addr;
`endif

  assign w_level    = r_wptr - r_rptr;
  assign w_full     = (w_level == LVL_W'(FIFO_DEPTH));
  assign w_empty    = (w_level == '0);
  assign w_head     = r_fifo[r_rptr[PTR_W-1:0]];
  assign o_wr_ready = r_run & ~w_full;
  assign w_push     = i_wr_valid & o_wr_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is queued.
  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wptr[PTR_W-1:0]] <= w_push_ent;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_BLANK;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BLANK:  if (i_video_on)  w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (!i_video_on) w_state_nxt = ST_BLANK;
      default:   w_state_nxt = ST_BLANK;
    endcase
  end

  // Slot decision: scan owns pix_ce cycles of active video, every other cycle drains one FIFO entry.
  always_comb begin
    w_scan  = 1'b0;
    w_pop   = 1'b0;
    w_we    = 1'b0;
    w_err   = 1'b0;
    w_maddr = '0;
    if (r_run && i_pix_ce && (w_state_nxt == ST_ACTIVE)) begin
      w_scan  = 1'b1;
      w_maddr = w_scan_maddr;
    end else if (!w_empty) begin
      w_pop   = 1'b1;
      w_maddr = w_head_maddr;
      if (w_head.addr < FB_SIZE) w_we  = 1'b1;
      else                       w_err = 1'b1;
    end
  end

  assign o_mem_addr   = w_maddr;
  assign o_mem_we     = w_we;
  assign o_mem_wdata  = w_head.data;
  assign o_wr_err     = w_err;
  assign o_fifo_level = w_level;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run     <= 1'b0;
      r_scan_d1 <= 1'b0;
      r_rgb     <= '0;
      r_hs      <= 2'b11;
      r_vs      <= 2'b11;
      r_vid     <= 2'b00;
    end else begin
      r_run     <= 1'b1;
      r_scan_d1 <= w_scan;
      if (r_scan_d1) r_rgb <= i_mem_rdata;
      r_hs      <= {r_hs[0], i_h_sync_in};
      r_vs      <= {r_vs[0], i_v_sync_in};
      r_vid     <= {r_vid[0], i_video_on};
    end
  end

  assign o_rgb_out      = r_vid[1] ? r_rgb : '0;
  assign o_h_sync_out   = r_hs[1];
  assign o_v_sync_out   = r_vs[1];
  assign o_video_on_out = r_vid[1];
endmodule
